// File: rtl/mult_uart_sequencer.sv
// Multiplier sequencer. It takes operands A and B from the UART RX byte stream, then streams the 16-bit product out through the TX handshake.
// Defining MULT_SEQ_CHECKSUM_EN appends a third XOR checksum byte to every frame (SEND_CK state).
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  GET_A     | idle, waiting for operand A byte
//  GET_B     | A held, waiting for operand B (timeout counter running)
//  CALC      | operands stable on multiplier for one cycle, product captured
//  SEND_0    | first product byte offered on TX, held until accepted
//  SEND_1    | second product byte offered on TX, held until accepted
//  SEND_CK   | checksum byte offered on TX (MULT_SEQ_CHECKSUM_EN only)
module mult_uart_sequencer #(
    parameter bit MSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_result,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        overrun,
    output logic        timeout
);

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_CALC,
        ST_SEND_0,
        ST_SEND_1
`ifdef MULT_SEQ_CHECKSUM_EN
        ,
        ST_SEND_CK
`endif
    } state_t;

    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        mul_a_q, mul_a_d;
    logic [7:0]        mul_b_q, mul_b_d;
    logic [15:0]       prod_q, prod_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic [TO_W-1:0]   ctr_q, ctr_d;

    logic [7:0]        first_byte;
    logic [7:0]        second_byte;
    logic              accepting;

    // The first byte comes straight from the multiplier so that it leaves CALC together with the product capture.
    assign first_byte  = MSB_FIRST ? mul_result[15:8] : mul_result[7:0];
    assign second_byte = MSB_FIRST ? prod_q[7:0]      : prod_q[15:8];
    assign accepting   = (state_q == ST_GET_A) || (state_q == ST_GET_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_GET_A;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            prod_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            ctr_q      <= '0;
        end else begin
            state_q    <= state_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            prod_q     <= prod_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            ctr_q      <= ctr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        prod_d     = prod_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        overrun_d  = overrun_q;
        timeout_d  = 1'b0;
        ctr_d      = ctr_q;

        if (rx_valid && !accepting) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_GET_A: begin
                if (rx_valid) begin
                    mul_a_d = rx_data;
                    ctr_d   = '0;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                // An arriving B byte takes priority over expiry in the same cycle.
                if (rx_valid) begin
                    mul_b_d = rx_data;
                    state_d = ST_CALC;
                end else if (TO_EN && (ctr_q == TO_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_GET_A;
                end else begin
                    ctr_d = ctr_q + TO_W'(1);
                end
            end
            ST_CALC: begin
                prod_d     = mul_result;
                tx_data_d  = first_byte;
                tx_valid_d = 1'b1;
                state_d    = ST_SEND_0;
            end
            ST_SEND_0: begin
                if (tx_ready) begin
                    tx_data_d = second_byte;
                    state_d   = ST_SEND_1;
                end
            end
            ST_SEND_1: begin
                if (tx_ready) begin
`ifdef MULT_SEQ_CHECKSUM_EN
                    tx_data_d = prod_q[15:8] ^ prod_q[7:0];
                    state_d   = ST_SEND_CK;
`else
                    tx_valid_d = 1'b0;
                    state_d    = ST_GET_A;
`endif
                end
            end
`ifdef MULT_SEQ_CHECKSUM_EN
            ST_SEND_CK: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_GET_A;
                end
            end
`endif
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_GET_A;
            end
        endcase
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != ST_GET_A);
    assign overrun  = overrun_q;
    assign timeout  = timeout_q;

endmodule
